// File: rtl/mem_resp_demux.sv
// mem_resp_demux: return path of the shared single-port memory.
// Keeps an in-order FIFO of destination tags (0 = port a / fetch,
// 1 = port b / data), one per outstanding request, and steers each memory
// response to the port that issued the matching request. Responses come out
// on registered per-port valid/data pairs one cycle after rsp_valid.
module mem_resp_demux #(
  parameter int n     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_fire,
  input  logic                     req_sel,
  input  logic                     rsp_valid,
  input  logic [n-1:0]             rsp_data,
  output logic                     ya_valid,
  output logic [n-1:0]             ya_data,
  output logic                     yb_valid,
  output logic [n-1:0]             yb_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] tags_q, tags_d;
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             yaValid_q, yaValid_d;
  logic [n-1:0]     yaData_q, yaData_d;
  logic             ybValid_q, ybValid_d;
  logic [n-1:0]     ybData_q, ybData_d;
  logic             err_q, err_d;

  logic isFull, isEmpty;
  logic pop, push, overflow, underflow;
  logic headTag;

  // Occupancy flags come from the registered count, never from pointer compare.
  always_comb begin
    isFull    = (count_q == CW'(DEPTH));
    isEmpty   = (count_q == '0);
    headTag   = tags_q[rdPtr_q];
    pop       = rsp_valid && !isEmpty;
    push      = req_fire && (!isFull || pop);
    overflow  = req_fire && isFull && !pop;
    underflow = rsp_valid && isEmpty;
  end

  // Next state: pop uses the pre-edge head, push writes at the write pointer.
  always_comb begin
    tags_d    = tags_q;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    yaValid_d = 1'b0;
    ybValid_d = 1'b0;
    yaData_d  = yaData_q;
    ybData_d  = ybData_q;
    err_d     = err_q || overflow || underflow;

    if (push) begin
      tags_d[wrPtr_q] = req_sel;
      wrPtr_d         = wrPtr_q + PW'(1);
    end

    if (pop) begin
      rdPtr_d = rdPtr_q + PW'(1);
      if (headTag == 1'b0) begin
        yaValid_d = 1'b1;
        yaData_d  = rsp_data;
      end else begin
        ybValid_d = 1'b1;
        ybData_d  = rsp_data;
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every outstanding tag immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tags_q    <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      yaValid_q <= 1'b0;
      yaData_q  <= '0;
      ybValid_q <= 1'b0;
      ybData_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      tags_q    <= tags_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      yaValid_q <= yaValid_d;
      yaData_q  <= yaData_d;
      ybValid_q <= ybValid_d;
      ybData_q  <= ybData_d;
      err_q     <= err_d;
    end
  end

  // Output mapping.
  always_comb begin
    ya_valid = yaValid_q;
    ya_data  = yaData_q;
    yb_valid = ybValid_q;
    yb_data  = ybData_q;
    full     = isFull;
    empty    = isEmpty;
    count    = count_q;
    err      = err_q;
  end

endmodule

// File: tb/tb_mem_resp_demux.sv
// tb_mem_resp_demux: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_mem_resp_demux;

  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          req_fire;
  logic          req_sel;
  logic          rsp_valid;
  logic [N-1:0]  rsp_data;
  logic          ya_valid;
  logic [N-1:0]  ya_data;
  logic          yb_valid;
  logic [N-1:0]  yb_data;
  logic          full;
  logic          empty;
  logic [2:0]    count;
  logic          err;

  int total;
  int bad;

  // Reference model: a queue of destination tags plus the registered outputs.
  logic          tagQ[$];
  logic          mYaV, mYbV, mErr;
  logic [N-1:0]  mYaD, mYbD;

  typedef struct {
    logic        fire;
    logic        sel;
    logic        rv;
    logic [31:0] data;
    logic        eYaV;
    logic        eYbV;
    logic [31:0] eYaD;
    logic [31:0] eYbD;
    int          eCount;
    logic        eErr;
  } vec_t;

  vec_t vecs[9];

  mem_resp_demux #(.n(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_fire  (req_fire),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .ya_valid  (ya_valid),
    .ya_data   (ya_data),
    .yb_valid  (yb_valid),
    .yb_data   (yb_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .err       (err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    tagQ.delete();
    mYaV = 1'b0;
    mYbV = 1'b0;
    mYaD = '0;
    mYbD = '0;
    mErr = 1'b0;
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic applyStimulus(input logic fire, input logic sel, input logic rv,
                               input logic [31:0] data);
    logic popOk, pushOk, t;
    req_fire  = fire;
    req_sel   = sel;
    rsp_valid = rv;
    rsp_data  = data;
    @(posedge clk);
    popOk  = rv && (tagQ.size() > 0);
    pushOk = fire && ((tagQ.size() < DEPTH) || popOk);
    mYaV   = 1'b0;
    mYbV   = 1'b0;
    if (popOk) begin
      t = tagQ.pop_front();
      if (t) begin mYbV = 1'b1; mYbD = data; end
      else   begin mYaV = 1'b1; mYaD = data; end
    end
    if (pushOk) tagQ.push_back(sel);
    if ((fire && !pushOk) || (rv && !popOk)) mErr = 1'b1;
    #1;
  endtask

  // Compare every DUT output with the model.
  task automatic checkOutput();
    check("ya_valid", 32'(ya_valid), 32'(mYaV));
    check("yb_valid", 32'(yb_valid), 32'(mYbV));
    check("ya_data",  ya_data,       mYaD);
    check("yb_data",  yb_data,       mYbD);
    check("count",    32'(count),    32'(tagQ.size()));
    check("full",     32'(full),     32'(tagQ.size() == DEPTH));
    check("empty",    32'(empty),    32'(tagQ.size() == 0));
    check("err",      32'(err),      32'(mErr));
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic pulseReset();
    rst_n     = 1'b0;
    req_fire  = 1'b0;
    rsp_valid = 1'b0;
    modelReset();
    #1;
    check("rst_count",  32'(count),    32'd0);
    check("rst_empty",  32'(empty),    32'd1);
    check("rst_full",   32'(full),     32'd0);
    check("rst_err",    32'(err),      32'd0);
    check("rst_yaV",    32'(ya_valid), 32'd0);
    check("rst_ybV",    32'(yb_valid), 32'd0);
    check("rst_yaD",    ya_data,       32'd0);
    check("rst_ybD",    yb_data,       32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    req_fire  = 1'b0;
    req_sel   = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    modelReset();

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  2, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  3, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  4, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'hA0, 1'b1, 1'b0, 32'hA0, 32'h0,  3, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'hB1, 1'b0, 1'b1, 32'hA0, 32'hB1, 2, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 32'hB2, 1'b0, 1'b1, 32'hA0, 32'hB2, 1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 32'hA3, 1'b1, 1'b0, 32'hA3, 32'hB2, 0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'hA3, 32'hB2, 0, 1'b0};

    // Reset, then idle.
    pulseReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput();

    // Directed table: push 0,1,1,0 then four back-to-back responses.
    $display("[TB] vector table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].fire, vecs[i].sel, vecs[i].rv, vecs[i].data);
      check("vec_yaV",   32'(ya_valid), 32'(vecs[i].eYaV));
      check("vec_ybV",   32'(yb_valid), 32'(vecs[i].eYbV));
      check("vec_yaD",   ya_data,       vecs[i].eYaD);
      check("vec_ybD",   yb_data,       vecs[i].eYbD);
      check("vec_count", 32'(count),    32'(vecs[i].eCount));
      check("vec_err",   32'(err),      32'(vecs[i].eErr));
      checkOutput();
    end

    // Fill to full, then 10 cycles of simultaneous push and pop across wrap.
    $display("[TB] full streaming");
    pulseReset();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'(i % 2), 1'b0, 32'h0);
      checkOutput();
    end
    check("fill_full", 32'(full), 32'd1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'((i + 1) % 2), 1'b1, 32'h100 + 32'(i));
      check("stream_full",  32'(full),  32'd1);
      check("stream_count", 32'(count), 32'd4);
      checkOutput();
    end

    // Overflow while full, then drain the four surviving tags.
    $display("[TB] overflow and drain");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check("ovf_err",   32'(err),   32'd1);
    check("ovf_count", 32'(count), 32'd4);
    checkOutput();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h200 + 32'(i));
      checkOutput();
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Underflow with a same-cycle push; the push still lands.
    $display("[TB] underflow");
    pulseReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hDEAD);
    check("udf_yaV",   32'(ya_valid), 32'd0);
    check("udf_ybV",   32'(yb_valid), 32'd0);
    check("udf_err",   32'(err),      32'd1);
    check("udf_count", 32'(count),    32'd1);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h55);
    check("udf_ybV2", 32'(yb_valid), 32'd1);
    check("udf_ybD2", yb_data,       32'h55);
    checkOutput();

    // Reset in the middle of a stream discards outstanding tags.
    $display("[TB] mid-stream reset");
    pulseReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h77);
    checkOutput();
    pulseReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h99);
    check("postrst_err", 32'(err),      32'd1);
    check("postrst_yaV", 32'(ya_valid), 32'd0);
    checkOutput();

    // Randomized traffic, with occasional resets to clear err.
    $display("[TB] random traffic");
    pulseReset();
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 99) pulseReset();
      applyStimulus(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 9) < 5), $urandom);
      checkOutput();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_resp_demux.md
Name: mem_resp_demux

Overview:
- Return path of the shared single-port memory.
- The request side selects between fetch (port a) and data (port b) with a 2:1 select. This block steers each memory response back to whichever port issued the matching request.
- It keeps an in-order FIFO of destination tags, one per outstanding request. Each response is delivered on a registered per-port valid/data pair.
- Sits between the memory read-data bus and the IF/MEM stages.

Parameters:
- n, 32, response data width in bits.
- DEPTH, 4, maximum outstanding requests. Power of two, ≥2.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_fire  input  1  a request was accepted by memory this cycle.
- req_sel  input  1  destination of that request: 0 = port a (fetch), 1 = port b (data).
- rsp_valid  input  1  memory returns one response this cycle.
- rsp_data  input  n  response data.
- ya_valid  output  1  one-cycle pulse: ya_data is a new port-a response.
- ya_data  output  n  port-a response data.
- yb_valid  output  1  one-cycle pulse: yb_data is a new port-b response.
- yb_data  output  n  port-b response data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH)+1  number of outstanding requests.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - tag FIFO emptied; read and write pointers = 0; count = 0.
  - ya_valid = yb_valid = 0; ya_data = yb_data = 0; err = 0.
  - empty = 1, full = 0.
  - Reset mid-operation discards every outstanding tag. Outputs go to reset values immediately, not at the next edge.
- Push: on a rising edge with req_fire=1 and (full=0 or a pop occurs on the same edge):
  - req_sel is written at the write pointer;
  - the write pointer advances modulo DEPTH.
- Pop: on a rising edge with rsp_valid=1 and empty=0:
  - head tag is read and the read pointer advances modulo DEPTH;
  - if head tag = 0: ya_data <= rsp_data and ya_valid <= 1;
  - if head tag = 1: yb_data <= rsp_data and yb_valid <= 1.
- Latency: exactly 1 cycle from rsp_valid to the corresponding y*_valid.
  - y*_valid is high for one cycle per response.
  - At most one of ya_valid/yb_valid is high in any cycle.
- Data hold: y*_data holds its last value until that port's next response. It is never overwritten by the other port's responses.
- Ordering: responses are strictly in request order. There is no reordering or ID matching.
- Pop-head rule: a pop always uses the head as it stood before the edge. A same-cycle push is never bypassed to a same-cycle response.
- Simultaneous push and pop:
  - allowed at any occupancy, including full;
  - count unchanged; both pointers advance.
- Count update per edge: count +1 on push only, −1 on pop only, unchanged otherwise or on both.
- Error cases (both set err and leave it high until reset):
  - Overflow: req_fire=1, full=1, no pop. The request is dropped; FIFO and count unchanged.
  - Underflow: rsp_valid=1 with empty=1, including when req_fire is also high that cycle. No y*_valid is produced and rsp_data is discarded. A simultaneous push still occurs.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. full and empty are derived from count, not from pointer compare.
- full, empty, count: combinational from registered count; reflect state after the most recent edge.

Test Plan:
- Reset then idle → count=0, empty=1, full=0, err=0, ya_valid=yb_valid=0, ya_data=yb_data=0.
- Push tags 0,1,1,0 on consecutive cycles, then responses 0xA0,0xB1,0xB2,0xA3 back-to-back → ya pulses with 0xA0 then 0xA3, yb pulses with 0xB1 then 0xB2, each exactly 1 cycle after its rsp_valid; afterwards ya_data=0xA3, yb_data=0xB2, count=0, err=0.
- Fill to DEPTH=4 (full=1), then req_fire+rsp_valid together for 10 cycles with alternating req_sel → full stays 1, count stays 4, responses route in issue order across pointer wrap, err=0.
- With full=1, req_fire alone → request dropped, err=1, count=4; drain 4 responses → exactly the 4 original tags' routing, then empty=1.
- With empty=1, rsp_valid and req_fire(sel=1) in the same cycle → no y*_valid, err=1, count=1; next rsp_valid 0x55 → yb_valid with yb_data=0x55.
- Push 3 tags, assert rst_n=0 mid-stream for 1 cycle → count=0, empty=1, err=0, both valids 0; a subsequent rsp_valid sets err=1.
